// File: rtl/iob_uart_buffered_pkg.sv
// iob_uart_buffered shared definitions: register map,
// STATUS/CTRL bit positions, FSM encodings, CTRL reset value.
package iob_uart_buffered_pkg;

  localparam logic [2:0] REG_DIV    = 3'd0;
  localparam logic [2:0] REG_TXDATA = 3'd1;
  localparam logic [2:0] REG_RXDATA = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_LEVEL  = 3'd5;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RXOVR    = 4;
  localparam int ST_FRERR    = 5;
  localparam int ST_TX_BUSY  = 6;
  localparam int ST_TXOVF    = 7;

  localparam int CT_TX_EN   = 0;
  localparam int CT_RX_EN   = 1;
  localparam int CT_FLOW_EN = 2;
  localparam int CT_IRQ_RX  = 3;
  localparam int CT_IRQ_TXE = 4;

  localparam logic [4:0] CTRL_RST = 5'h03;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

endpackage

// File: rtl/iob_sync_fifo.sv
// iob_sync_fifo: synchronous FIFO, head word read from the register array.
// Ports: clk, rst, push/din, pop/dout, full, empty, level (AW+1 bits).
module iob_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // a pop frees the slot in the same cycle, so push on full succeeds
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/iob_uart_buffered.sv
// iob_uart_buffered: 8N1 UART with TX/RX FIFOs on the native CPU bus.
// Ports: clk, rst, valid/address/wdata/wstrb/rdata/ready, txd, rxd, cts, rts, interrupt.
module iob_uart_buffered
  import iob_uart_buffered_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TXFIFO_AW   = 4,
  parameter int RXFIFO_AW   = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 867
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                txd,
  input  logic                rxd,
  input  logic                cts,
  output logic                rts,
  output logic                interrupt
);

  localparam int RXDEPTH = 1 << RXFIFO_AW;

  logic       acc, wr, w1c;
  logic [2:0] idx;
  logic [DIV_W-1:0] div_q;
  logic [4:0] ctrl;
  logic       rxovr, frerr, txovf;
  logic       tx_en, rx_en, flow_en;
  logic [1:0] rxd_sync, cts_sync;
  logic       rxd_s, cts_s;
  logic [31:0] rd32;
  logic       unused_bits;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic [TXFIFO_AW:0] tx_level;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_dout;
  logic [RXFIFO_AW:0] rx_level;

  tx_state_t  tx_state;
  logic [DIV_W-1:0] tx_cnt, tx_div;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic       tx_go, tx_tick, tx_busy;

  rx_state_t  rx_state;
  logic [DIV_W-1:0] rx_cnt, rx_div;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic       rx_tick, rx_half, rx_ferr;

  assign unused_bits = ^{wdata, address};

  assign acc = valid & ~ready;
  assign wr  = |wstrb;
  assign idx = address[4:2];
  assign w1c = acc & wr & (idx == REG_STATUS);

  assign tx_en   = ctrl[CT_TX_EN];
  assign rx_en   = ctrl[CT_RX_EN];
  assign flow_en = ctrl[CT_FLOW_EN];
  assign rxd_s   = rxd_sync[1];
  assign cts_s   = cts_sync[1];

  assign tx_push = acc & wr & (idx == REG_TXDATA);
  assign rx_pop  = acc & ~wr & (idx == REG_RXDATA);

  iob_sync_fifo #(.DATA_W(8), .AW(TXFIFO_AW)) u_txfifo (
    .clk(clk), .rst(rst),
    .push(tx_push), .din(wdata[7:0]),
    .pop(tx_pop), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  iob_sync_fifo #(.DATA_W(8), .AW(RXFIFO_AW)) u_rxfifo (
    .clk(clk), .rst(rst),
    .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_sync <= 2'b11;
      cts_sync <= 2'b11;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd};
      cts_sync <= {cts_sync[0], cts};
    end
  end

  // a frame may start from IDLE or straight out of STOP (no idle gap)
  assign tx_go   = tx_en & ~tx_empty & (~flow_en | cts_s);
  assign tx_tick = tx_cnt == tx_div;
  assign tx_busy = tx_state != TX_IDLE;
  assign tx_pop  = tx_go & ((tx_state == TX_IDLE) |
                            ((tx_state == TX_STOP) & tx_tick));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state <= TX_START;
            txd      <= 1'b0;
            tx_sh    <= tx_dout;
            tx_div   <= div_q;
            tx_cnt   <= '0;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            txd      <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              txd    <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_state <= TX_START;
              txd      <= 1'b0;
              tx_sh    <= tx_dout;
              tx_div   <= div_q;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // start bit checked half a period in; later bits one period apart
  assign rx_tick = rx_cnt == rx_div;
  assign rx_half = rx_cnt == (rx_div >> 1);
  assign rx_push = (rx_state == RX_STOP) & rx_tick & rxd_s;
  assign rx_ferr = (rx_state == RX_STOP) & rx_tick & ~rxd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_en & ~rxd_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
            rx_div   <= div_q;
          end
        end
        RX_START: begin
          if (rx_half) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_sh  <= {rxd_s, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else rx_bit <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rd32 = '0;
    case (idx)
      REG_DIV:    rd32 = 32'(div_q);
      REG_RXDATA: rd32 = rx_empty ? 32'h0 : {24'h0, rx_dout};
      REG_STATUS: rd32 = {24'h0, txovf, tx_busy, frerr, rxovr,
                          rx_full, rx_empty, tx_empty, tx_full};
      REG_CTRL:   rd32 = {27'h0, ctrl};
      REG_LEVEL:  rd32 = {16'(rx_level), 16'(tx_level)};
      default:    rd32 = '0;
    endcase
  end

  // error set wins over a same-cycle W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      ready     <= 1'b0;
      rdata     <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      ctrl      <= CTRL_RST;
      rxovr     <= 1'b0;
      frerr     <= 1'b0;
      txovf     <= 1'b0;
      rts       <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      ready <= acc;
      rdata <= (acc & ~wr) ? DATA_W'(rd32) : '0;
      if (acc & wr & (idx == REG_DIV))  div_q <= wdata[DIV_W-1:0];
      if (acc & wr & (idx == REG_CTRL)) ctrl  <= wdata[4:0];
      txovf <= (tx_push & tx_full & ~tx_pop) |
               (txovf & ~(w1c & wdata[ST_TXOVF]));
      rxovr <= (rx_push & rx_full & ~rx_pop) |
               (rxovr & ~(w1c & wdata[ST_RXOVR]));
      frerr <= rx_ferr | (frerr & ~(w1c & wdata[ST_FRERR]));
      rts <= rx_en & (~flow_en |
             (rx_level <= (RXFIFO_AW+1)'(RXDEPTH - 2)));
      interrupt <= (ctrl[CT_IRQ_RX] & ~rx_empty) |
                   (ctrl[CT_IRQ_TXE] & tx_empty & ~tx_busy);
    end
  end

endmodule

// File: tb/tb_iob_uart_buffered.sv
// Directed self-checking bench for iob_uart_buffered.
// Drives the CPU bus and serial lines, checks against hand-computed values.
module tb_iob_uart_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [4:0]  address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        txd;
  logic        rxd_w;
  logic        rxd_drv;
  logic        loop;
  logic        cts;
  logic        rts;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  assign rxd_w = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  iob_uart_buffered dut (
    .clk(clk), .rst(rst),
    .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready),
    .txd(txd), .rxd(rxd_w),
    .cts(cts), .rts(rts),
    .interrupt(interrupt)
  );

  task automatic bus(input logic [2:0] idx, input logic wr,
                     input logic [31:0] d, output logic [31:0] q);
    int n;
    @(negedge clk);
    valid   = 1'b1;
    address = {idx, 2'b00};
    wdata   = d;
    wstrb   = wr ? 4'hf : 4'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 8);
    q = rdata;
    if (!ready) begin
      errors++;
      $display("FAIL bus_timeout idx=%0d", idx);
    end
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [31:0] d);
    logic [31:0] q;
    bus(idx, 1'b1, d, q);
  endtask

  task automatic rd_reg(input logic [2:0] idx, output logic [31:0] q);
    bus(idx, 1'b0, 32'h0, q);
  endtask

  // one 8N1 frame at 10 cycles per bit (DIV=9)
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd_drv = f[i];
      repeat (9) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [31:0] q;
    rst = 1'b1; valid = 1'b0; wstrb = 4'h0;
    address = '0; wdata = '0;
    rxd_drv = 1'b1; loop = 1'b0; cts = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, txd, rts, interrupt} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=0100",
               {ready, txd, rts, interrupt});
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    rd_reg(3'd0, q);
    checks++;
    if (q !== 32'd867) begin
      errors++; $display("FAIL reset_div got=%0d exp=867", q);
    end
    rd_reg(3'd4, q);
    checks++;
    if (q !== 32'h3) begin
      errors++; $display("FAIL reset_ctrl got=%h exp=3", q);
    end
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h06) begin
      errors++; $display("FAIL reset_status got=%h exp=06", q);
    end
    rd_reg(3'd5, q);
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL reset_level got=%h exp=0", q);
    end
    checks++;
    if (rts !== 1'b1) begin
      errors++; $display("FAIL rts_after_reset got=%b exp=1", rts);
    end
    wr_reg(3'd4, 32'h13);
    repeat (2) @(negedge clk);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL irq_txe got=%b exp=1", interrupt);
    end
    wr_reg(3'd4, 32'h03);
    repeat (2) @(negedge clk);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL irq_off got=%b exp=0", interrupt);
    end
  endtask

  task automatic test_tx_frame;
    logic [31:0] q;
    logic [9:0]  fr;
    int bad, first;
    wr_reg(3'd0, 32'd9);
    wr_reg(3'd1, 32'h55);
    fr = {1'b1, 8'h55, 1'b0};
    bad = 0; first = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txd !== fr[k/10]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tx_frame_55 bad_cycles=%0d first=%0d exp=0",
               bad, first);
    end
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h06) begin
      errors++; $display("FAIL tx_done_status got=%h exp=06", q);
    end
  endtask

  task automatic test_loopback;
    logic [31:0] q;
    loop = 1'b1;
    wr_reg(3'd1, 32'hA3);
    repeat (130) @(negedge clk);
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h02) begin
      errors++; $display("FAIL loop_status got=%h exp=02", q);
    end
    rd_reg(3'd5, q);
    checks++;
    if (q !== 32'h00010000) begin
      errors++; $display("FAIL loop_level got=%h exp=00010000", q);
    end
    rd_reg(3'd2, q);
    checks++;
    if (q !== 32'hA3) begin
      errors++; $display("FAIL loop_rxdata got=%h exp=a3", q);
    end
    rd_reg(3'd2, q);
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL loop_rx_empty_read got=%h exp=0", q);
    end
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h06) begin
      errors++; $display("FAIL loop_status2 got=%h exp=06", q);
    end
    loop = 1'b0;
  endtask

  task automatic test_tx_overflow;
    logic [31:0] q;
    wr_reg(3'd4, 32'h02);
    for (int i = 0; i < 17; i++) wr_reg(3'd1, 32'(i));
    rd_reg(3'd5, q);
    checks++;
    if (q !== 32'h10) begin
      errors++; $display("FAIL txovf_level got=%h exp=10", q);
    end
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h85) begin
      errors++; $display("FAIL txovf_status got=%h exp=85", q);
    end
    wr_reg(3'd3, 32'h80);
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h05) begin
      errors++; $display("FAIL txovf_w1c got=%h exp=05", q);
    end
    wr_reg(3'd4, 32'h03);
    repeat (1700) @(negedge clk);
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h06) begin
      errors++; $display("FAIL tx_drain_status got=%h exp=06", q);
    end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] q;
    int bad;
    for (int i = 0; i < 17; i++) send_rx(8'(8'h30 + i), 1'b1);
    repeat (5) @(negedge clk);
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h1A) begin
      errors++; $display("FAIL rxovr_status got=%h exp=1a", q);
    end
    rd_reg(3'd5, q);
    checks++;
    if (q !== 32'h00100000) begin
      errors++; $display("FAIL rxovr_level got=%h exp=00100000", q);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd_reg(3'd2, q);
      checks++;
      if (q !== 32'(8'h30 + i)) begin
        errors++;
        $display("FAIL rx_byte_%0d got=%h exp=%h", i, q, 8'h30 + i);
      end
    end
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h16) begin
      errors++; $display("FAIL rxovr_drained got=%h exp=16", q);
    end
    wr_reg(3'd3, 32'h10);
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h06) begin
      errors++; $display("FAIL rxovr_w1c got=%h exp=06", q);
    end
  endtask

  task automatic test_frame_error;
    logic [31:0] q;
    send_rx(8'h5A, 1'b0);
    @(negedge clk);
    rxd_drv = 1'b1;
    repeat (30) @(negedge clk);
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h26) begin
      errors++; $display("FAIL frerr_status got=%h exp=26", q);
    end
    rd_reg(3'd5, q);
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL frerr_level got=%h exp=0", q);
    end
    wr_reg(3'd3, 32'h20);
    rd_reg(3'd3, q);
    checks++;
    if (q !== 32'h06) begin
      errors++; $display("FAIL frerr_w1c got=%h exp=06", q);
    end
  endtask

  task automatic test_flow_control;
    logic [31:0] q;
    int bad;
    logic found;
    wr_reg(3'd4, 32'h07);
    cts = 1'b0;
    repeat (4) @(negedge clk);
    wr_reg(3'd1, 32'h11);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL cts_hold bad_cycles=%0d exp=0", bad);
    end
    @(negedge clk);
    cts = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL cts_start got=%b exp=1", found);
    end
    repeat (110) @(negedge clk);
    checks++;
    if (rts !== 1'b1) begin
      errors++; $display("FAIL rts_empty got=%b exp=1", rts);
    end
    for (int i = 0; i < 14; i++) send_rx(8'(8'h60 + i), 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (rts !== 1'b1) begin
      errors++; $display("FAIL rts_free2 got=%b exp=1", rts);
    end
    send_rx(8'h6E, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (rts !== 1'b0) begin
      errors++; $display("FAIL rts_free1 got=%b exp=0", rts);
    end
    rd_reg(3'd5, q);
    checks++;
    if (q !== 32'h000F0000) begin
      errors++; $display("FAIL flow_level got=%h exp=000f0000", q);
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] q;
    wr_reg(3'd4, 32'h03);
    wr_reg(3'd1, 32'hF0);
    wr_reg(3'd1, 32'h77);
    repeat (43) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL midframe_bit3 got=%b exp=0", txd);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      errors++; $display("FAIL reset_txd got=%b exp=1", txd);
    end
    rst = 1'b0;
    @(negedge clk);
    rd_reg(3'd5, q);
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL rst_level got=%h exp=0", q);
    end
    rd_reg(3'd0, q);
    checks++;
    if (q !== 32'd867) begin
      errors++; $display("FAIL rst_div got=%0d exp=867", q);
    end
    checks++;
    if (txd !== 1'b1) begin
      errors++; $display("FAIL rst_txd_idle got=%b exp=1", txd);
    end
  endtask

  initial begin
    test_reset;
    test_tx_frame;
    test_loopback;
    test_tx_overflow;
    test_rx_overflow;
    test_frame_error;
    test_flow_control;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
